// File: rtl/kw_sram_fifo_ctrl_if.sv
// Stream and SRAM-macro signal bundle for kw_sram_fifo_ctrl.
// The master side is the controller; the slave side is its environment.
interface kw_sram_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 9
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  sram_cs_n;
  logic                  sram_we_n;
  logic                  sram_re_n;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_wdata;
  logic [DATA_WIDTH-1:0] sram_rdata;
  logic [CNT_WIDTH-1:0]  count;

  modport master (
    input  in_valid, in_data, out_ready, sram_rdata,
    output in_ready, out_valid, out_data,
    output sram_cs_n, sram_we_n, sram_re_n, sram_addr, sram_wdata, count
  );

  modport slave (
    output in_valid, in_data, out_ready, sram_rdata,
    input  in_ready, out_valid, out_data,
    input  sram_cs_n, sram_we_n, sram_re_n, sram_addr, sram_wdata, count
  );
endinterface

// File: rtl/kw_sram_fifo_ctrl.sv
// Valid/ready FIFO built on one single-port 1RW SRAM, with a 2-entry prefetch
// buffer that hides the SRAM's one-cycle read latency.
module kw_sram_fifo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int CNT_WIDTH  = $clog2(DEPTH + 3)
) (
  input logic                 clock,
  input logic                 reset_n,
  kw_sram_fifo_ctrl_if.master bus
);

  localparam logic [ADDR_WIDTH:0] MEM_FULL = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] MEM_ZERO = {(ADDR_WIDTH + 1){1'b0}};

  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [ADDR_WIDTH-1:0] addr_hold_r;
  logic [ADDR_WIDTH:0]   mem_cnt_r;
  logic                  rd_inflight_r;
  logic [DATA_WIDTH-1:0] buf0_r;
  logic [DATA_WIDTH-1:0] buf1_r;
  logic [1:0]            buf_cnt_r;
  logic [CNT_WIDTH-1:0]  count_r;

  logic       pop_s;
  logic       push_s;
  logic [2:0] buf_need_s;
  logic       rd_want_s;
  logic       rd_urgent_s;
  logic       in_ready_s;
  logic       wr_gnt_s;
  logic       rd_gnt_s;

  // Arbitration of the single SRAM port between producer writes and prefetch reads
  always_comb begin
    pop_s       = (buf_cnt_r != 2'd0) && bus.out_ready;
    push_s      = rd_inflight_r;
    // Slots still claimed after this cycle's pop; counting the pop lets a
    // pop-only drain keep one read in flight every cycle.
    buf_need_s  = {1'b0, buf_cnt_r} + {2'b00, rd_inflight_r} - {2'b00, pop_s};
    rd_want_s   = (mem_cnt_r != MEM_ZERO) && (buf_need_s < 3'd2);
    rd_urgent_s = (mem_cnt_r != MEM_ZERO) && (buf_cnt_r == 2'd0) && !rd_inflight_r;
    in_ready_s  = reset_n && (mem_cnt_r < MEM_FULL) && !rd_urgent_s;
    wr_gnt_s    = bus.in_valid && in_ready_s;
    rd_gnt_s    = rd_want_s && !wr_gnt_s;
  end

  // SRAM command encoding for the granted operation
  always_comb begin
    bus.sram_cs_n  = 1'b1;
    bus.sram_we_n  = 1'b1;
    bus.sram_re_n  = 1'b1;
    bus.sram_addr  = addr_hold_r;
    bus.sram_wdata = bus.in_data;
    if (wr_gnt_s) begin
      bus.sram_cs_n = 1'b0;
      bus.sram_we_n = 1'b0;
      bus.sram_addr = wr_ptr_r;
    end else if (rd_gnt_s) begin
      bus.sram_cs_n = 1'b0;
      bus.sram_re_n = 1'b0;
      bus.sram_addr = rd_ptr_r;
    end else begin
      bus.sram_addr = addr_hold_r;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = (buf_cnt_r != 2'd0);
  assign bus.out_data  = buf0_r;
  assign bus.count     = count_r;

  // SRAM pointers, occupancy and total word count
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r      <= {ADDR_WIDTH{1'b0}};
      rd_ptr_r      <= {ADDR_WIDTH{1'b0}};
      addr_hold_r   <= {ADDR_WIDTH{1'b0}};
      mem_cnt_r     <= MEM_ZERO;
      rd_inflight_r <= 1'b0;
      count_r       <= {CNT_WIDTH{1'b0}};
    end else begin
      rd_inflight_r <= rd_gnt_s;
      if (wr_gnt_s) begin
        wr_ptr_r    <= wr_ptr_r + ADDR_WIDTH'(1);
        addr_hold_r <= wr_ptr_r;
        mem_cnt_r   <= mem_cnt_r + (ADDR_WIDTH + 1)'(1);
      end else if (rd_gnt_s) begin
        rd_ptr_r    <= rd_ptr_r + ADDR_WIDTH'(1);
        addr_hold_r <= rd_ptr_r;
        mem_cnt_r   <= mem_cnt_r - (ADDR_WIDTH + 1)'(1);
      end else begin
        mem_cnt_r   <= mem_cnt_r;
      end
      case ({wr_gnt_s, pop_s})
        2'b10:   count_r <= count_r + CNT_WIDTH'(1);
        2'b01:   count_r <= count_r - CNT_WIDTH'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Prefetch buffer: capture returning read data, release the head on pop
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      buf0_r    <= {DATA_WIDTH{1'b0}};
      buf1_r    <= {DATA_WIDTH{1'b0}};
      buf_cnt_r <= 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (buf_cnt_r == 2'd0) begin
            buf0_r <= bus.sram_rdata;
          end else begin
            buf1_r <= bus.sram_rdata;
          end
          buf_cnt_r <= buf_cnt_r + 2'd1;
        end
        2'b01: begin
          buf0_r    <= buf1_r;
          buf_cnt_r <= buf_cnt_r - 2'd1;
        end
        2'b11: begin
          if (buf_cnt_r == 2'd1) begin
            buf0_r <= bus.sram_rdata;
          end else begin
            buf0_r <= buf1_r;
            buf1_r <= bus.sram_rdata;
          end
        end
        default: begin
          buf_cnt_r <= buf_cnt_r;
        end
      endcase
    end
  end

endmodule
